// File: rtl/bk32_share_arb.sv
// Round-robin front end that time-shares one combinational 32-bit adder between
// NREQ requesters and queues tagged results in a small FIFO.
module bk32_share_arb #(
  parameter int NREQ  = 4,
  parameter int IDW   = 2,
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [31:0]       add_a,
  output logic [31:0]       add_b,
  input  logic [31:0]       add_sum,
  input  logic              add_cout,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [31:0]       res_sum,
  output logic              res_cout,
  output logic [IDW-1:0]    res_id,
  output logic [31:0]       op_cnt
);
  // Handshakes: a transfer happens on a cycle where valid and ready are both 1
  // at the rising edge; ready may depend on valid, valid must not depend on ready.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [IDW-1:0] rr;
  logic [IDW-1:0] grant;
  logic           found;
  logic           push;
  logic           pop;
  logic [CW-1:0]  count;
  logic [PW-1:0]  head;
  logic [PW-1:0]  tail;
  logic [31:0]    mem_sum  [DEPTH];
  logic           mem_cout [DEPTH];
  logic [IDW-1:0] mem_id   [DEPTH];

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // First valid requester at or above rr, wrapping around.
  always_comb begin
    int idx;
    found = 1'b0;
    grant = '0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        grant = IDW'(idx);
      end
    end
  end

  // No bypass: a full FIFO blocks issue even when the head is being popped.
  assign push = found && (count < CW'(DEPTH)) && !rst;
  assign pop  = res_valid && res_ready;

  always_comb begin
    req_ready = '0;
    add_a     = '0;
    add_b     = '0;
    if (push) begin
      req_ready[grant] = 1'b1;
      add_a = req_a[32*int'(grant) +: 32];
      add_b = req_b[32*int'(grant) +: 32];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr     <= '0;
      count  <= '0;
      head   <= '0;
      tail   <= '0;
      op_cnt <= '0;
    end else begin
      if (push) begin
        tail   <= ptr_next(tail);
        rr     <= IDW'((int'(grant) + 1) % NREQ);
        op_cnt <= op_cnt + 32'd1;
      end
      if (pop) head <= ptr_next(head);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; the outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_sum[tail]  <= add_sum;
      mem_cout[tail] <= add_cout;
      mem_id[tail]   <= grant;
    end
  end

  assign res_valid = (count != '0);
  assign res_sum   = res_valid ? mem_sum[head]  : '0;
  assign res_cout  = res_valid ? mem_cout[head] : 1'b0;
  assign res_id    = res_valid ? mem_id[head]   : '0;
endmodule
